// File: rtl/pipeline_hazard_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | ppu_pkg: shared types and constants for the pipeline hazard unit    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package ppu_pkg;

  localparam int CNT_W_DEFAULT = 16;

  localparam logic PC_SEL_SEQ   = 1'b0;
  localparam logic PC_SEL_REDIR = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if: pipeline hazard/fetch control bundle       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = ppu_pkg::CNT_W_DEFAULT
) ();

  logic             imem_ready;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_jal;
  logic [31:0]      id_jal_target;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_jalr;
  logic [31:0]      ex_target;

  logic             imem_req;
  logic             pc_we;
  logic             pc_sel;
  logic [31:0]      redirect_target;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  imem_ready, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jal,
           id_jal_target, ex_rd, ex_mem_read, ex_branch_taken, ex_jalr, ex_target,
    output imem_req, pc_we, pc_sel, redirect_target, ifid_we, ifid_flush,
           idex_flush, stall_cnt, flush_cnt
  );

  modport master (
    output imem_ready, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jal,
           id_jal_target, ex_rd, ex_mem_read, ex_branch_taken, ex_jalr, ex_target,
    input  imem_req, pc_we, pc_sel, redirect_target, ifid_we, ifid_flush,
           idex_flush, stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// +--------------------------------------------------------------------+
// | load_use_detect: flags an ID source that depends on an EX load      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module load_use_detect (
  input  wire logic       ex_mem_read_i,
  input  wire logic [4:0] ex_rd_i,
  input  wire logic [4:0] id_rs1_i,
  input  wire logic [4:0] id_rs2_i,
  input  wire logic       id_use_rs1_i,
  input  wire logic       id_use_rs2_i,
  output logic            load_use_o
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign w_hit_rs2  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush/redirect control for a 5-stage    |
// | RISC-V pipeline with event counters.  Rev 1.0                       |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import ppu_pkg::*;
#(
  parameter int CNT_W = ppu_pkg::CNT_W_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        w_load_use;
  logic        w_ex_redirect;
  logic        w_redirect;
  logic [31:0] w_redir_target;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rd_i       (bus.ex_rd),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_use_rs1_i  (bus.id_use_rs1),
    .id_use_rs2_i  (bus.id_use_rs2),
    .load_use_o    (w_load_use)
  );

  assign w_ex_redirect  = bus.ex_branch_taken || bus.ex_jalr;
  // A JAL in ID only redirects when nothing older is resolving or stalling it
  assign w_redirect     = w_ex_redirect || (!w_load_use && bus.id_jal);
  assign w_redir_target = w_ex_redirect ? bus.ex_target : bus.id_jal_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pend_target_q <= 32'h0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    pend_target_d       = pend_target_q;
    stall_cnt_d         = stall_cnt_q;
    flush_cnt_d         = flush_cnt_q;
    bus.imem_req        = 1'b0;
    bus.pc_we           = 1'b0;
    bus.pc_sel          = PC_SEL_SEQ;
    bus.redirect_target = pend_target_q;
    bus.ifid_we         = 1'b0;
    bus.ifid_flush      = 1'b0;
    bus.idex_flush      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
        state_d        = ST_RUN;
      end

      ST_RUN: begin
        bus.imem_req = 1'b1;
        bus.pc_we    = 1'b1;
        bus.ifid_we  = 1'b1;
        if (w_redirect) begin
          bus.redirect_target = w_redir_target;
          bus.ifid_flush      = 1'b1;
          // JAL must still reach EX to write its link register
          bus.idex_flush      = w_ex_redirect;
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
          if (bus.imem_ready) begin
            bus.pc_sel = PC_SEL_REDIR;
          end else begin
            bus.pc_we     = 1'b0;
            pend_target_d = w_redir_target;
            state_d       = ST_PENDING;
          end
        end else if (w_load_use) begin
          bus.pc_we      = 1'b0;
          bus.ifid_we    = 1'b0;
          bus.idex_flush = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (!bus.imem_ready) begin
          bus.pc_we      = 1'b0;
          bus.ifid_we    = 1'b0;
          bus.idex_flush = 1'b1;
        end
      end

      ST_PENDING: begin
        bus.imem_req   = 1'b1;
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
        if (bus.imem_ready) begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = PC_SEL_REDIR;
          state_d    = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed + random check against a model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;

  logic        r_ready, r_u1, r_u2, r_jal, r_emr, r_bt, r_jalr;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [31:0] r_jal_tgt, r_ex_tgt;

  int n_chk;
  int n_bad;

  // model: 0 = boot, 1 = run, 2 = waiting for a redirect fetch
  int          m_st;
  logic [31:0] m_pend;
  int          m_stall;
  int          m_flush;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if16 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if4  ();

  pipeline_hazard_ctrl #(.CNT_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  pipeline_hazard_ctrl #(.CNT_W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));

  for (genvar g = 0; g < 2; g++) begin : g_drive
    if (g == 0) begin : g_w16
      assign if16.imem_ready = r_ready;  assign if16.id_rs1 = r_rs1;  assign if16.id_rs2 = r_rs2;
      assign if16.id_use_rs1 = r_u1;     assign if16.id_use_rs2 = r_u2;
      assign if16.id_jal = r_jal;        assign if16.id_jal_target = r_jal_tgt;
      assign if16.ex_rd = r_rd;          assign if16.ex_mem_read = r_emr;
      assign if16.ex_branch_taken = r_bt; assign if16.ex_jalr = r_jalr; assign if16.ex_target = r_ex_tgt;
    end else begin : g_w4
      assign if4.imem_ready = r_ready;   assign if4.id_rs1 = r_rs1;   assign if4.id_rs2 = r_rs2;
      assign if4.id_use_rs1 = r_u1;      assign if4.id_use_rs2 = r_u2;
      assign if4.id_jal = r_jal;         assign if4.id_jal_target = r_jal_tgt;
      assign if4.ex_rd = r_rd;           assign if4.ex_mem_read = r_emr;
      assign if4.ex_branch_taken = r_bt; assign if4.ex_jalr = r_jalr; assign if4.ex_target = r_ex_tgt;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic idle();
    r_ready = 1'b1; r_u1 = 1'b0; r_u2 = 1'b0; r_jal = 1'b0; r_emr = 1'b0;
    r_bt = 1'b0; r_jalr = 1'b0; r_rs1 = 5'd0; r_rs2 = 5'd0; r_rd = 5'd0;
    r_jal_tgt = 32'h0; r_ex_tgt = 32'h0;
  endtask

  task automatic rand_inputs();
    r_ready   = ($urandom_range(0, 3) != 0);
    r_rs1     = 5'($urandom_range(0, 7));
    r_rs2     = 5'($urandom_range(0, 7));
    r_rd      = 5'($urandom_range(0, 7));
    r_u1      = 1'($urandom_range(0, 1));
    r_u2      = 1'($urandom_range(0, 1));
    r_emr     = ($urandom_range(0, 2) == 0);
    r_jal     = ($urandom_range(0, 5) == 0);
    r_bt      = ($urandom_range(0, 7) == 0);
    r_jalr    = ($urandom_range(0, 15) == 0);
    r_jal_tgt = $urandom & 32'hFFFF_FFFC;
    r_ex_tgt  = $urandom & 32'hFFFF_FFFC;
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model.
  task automatic cycle();
    logic e_req, e_pcwe, e_sel, e_ifwe, e_iff, e_idf, c_tgt, c_ifwe;
    logic red_ex, dep, take;
    logic [31:0] e_tgt;
    int nxt, add_s, add_f;
    @(negedge clk);
    e_req = 0; e_pcwe = 0; e_sel = 0; e_ifwe = 0; e_iff = 0; e_idf = 0;
    c_tgt = 0; c_ifwe = 1; e_tgt = 32'h0; nxt = m_st; add_s = 0; add_f = 0;
    red_ex = r_bt | r_jalr;
    dep = r_emr && (r_rd != 0) && ((r_u1 && r_rs1 == r_rd) || (r_u2 && r_rs2 == r_rd));
    take = red_ex || (!dep && r_jal);
    if (m_st == 0) begin
      e_iff = 1; e_idf = 1; nxt = 1;
    end else if (m_st == 1) begin
      e_req = 1; e_pcwe = 1; e_ifwe = 1;
      if (take) begin
        e_tgt = red_ex ? r_ex_tgt : r_jal_tgt;
        c_tgt = 1; e_iff = 1; e_idf = red_ex; add_f = 1;
        if (r_ready) e_sel = 1;
        else begin e_pcwe = 0; m_pend = e_tgt; nxt = 2; end
      end else if (dep || !r_ready) begin
        e_pcwe = 0; e_ifwe = 0; e_idf = 1; add_s = dep ? 1 : 0;
      end
    end else begin
      e_req = 1; e_iff = 1; e_idf = 1; e_tgt = m_pend; c_tgt = 1; c_ifwe = 0;
      if (r_ready) begin e_pcwe = 1; e_sel = 1; nxt = 1; end
    end
    chk("imem_req",   32'(if16.imem_req),   32'(e_req));
    chk("pc_we",      32'(if16.pc_we),      32'(e_pcwe));
    chk("pc_sel",     32'(if16.pc_sel),     32'(e_sel));
    chk("ifid_flush", 32'(if16.ifid_flush), 32'(e_iff));
    chk("idex_flush", 32'(if16.idex_flush), 32'(e_idf));
    if (c_ifwe) chk("ifid_we", 32'(if16.ifid_we), 32'(e_ifwe));
    if (c_tgt)  chk("redirect_target", if16.redirect_target, e_tgt);
    chk("pc_we_w4",    32'(if4.pc_we),      32'(e_pcwe));
    chk("stall_cnt",   32'(if16.stall_cnt), 32'(sat(m_stall, 16)));
    chk("flush_cnt",   32'(if16.flush_cnt), 32'(sat(m_flush, 16)));
    chk("stall_cnt_w4", 32'(if4.stall_cnt), 32'(sat(m_stall, 4)));
    chk("flush_cnt_w4", 32'(if4.flush_cnt), 32'(sat(m_flush, 4)));
    m_stall += add_s;
    m_flush += add_f;
    m_st = nxt;
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted away from any clock edge and must act immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_st = 0; m_pend = 32'h0; m_stall = 0; m_flush = 0;
    chk("rst_imem_req",   32'(if16.imem_req),   32'h0);
    chk("rst_pc_we",      32'(if16.pc_we),      32'h0);
    chk("rst_ifid_flush", 32'(if16.ifid_flush), 32'h1);
    chk("rst_idex_flush", 32'(if16.idex_flush), 32'h1);
    chk("rst_stall_cnt",  32'(if16.stall_cnt),  32'h0);
    chk("rst_flush_cnt",  32'(if16.flush_cnt),  32'h0);
    chk("rst_flush_w4",   32'(if4.flush_cnt),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic no_stale_check();
    chk("no_stale_target", 32'(if16.pc_sel && (if16.redirect_target == 32'h80)), 32'h0);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    m_st = 0; m_pend = 32'h0; m_stall = 0; m_flush = 0;
    rst_n = 1'b1;
    idle();
    #3;
    do_reset();

    // boot cycle then normal run
    cycle(); cycle(); cycle();

    // load-use through rs2: exactly one bubble, then load moves to MEM
    r_emr = 1; r_rd = 5'd5; r_rs2 = 5'd5; r_u2 = 1;
    cycle();
    idle(); cycle();
    r_emr = 1; r_rd = 5'd0; r_rs2 = 5'd0; r_u2 = 1;
    cycle();

    // taken branch outranks a simultaneous load-use and JAL
    idle();
    r_bt = 1; r_ex_tgt = 32'h100; r_emr = 1; r_rd = 5'd3; r_rs1 = 5'd3; r_u1 = 1;
    r_jal = 1; r_jal_tgt = 32'h200;
    cycle();
    idle(); cycle();

    // JAL with fetch not ready for three cycles
    r_jal = 1; r_jal_tgt = 32'h40; r_ready = 0;
    cycle();
    r_jal = 0; cycle(); cycle();
    r_ready = 1; cycle();
    cycle();

    // reset while waiting on a redirect to 0x80
    r_jal = 1; r_jal_tgt = 32'h80; r_ready = 0;
    cycle();
    r_jal = 0; cycle();
    do_reset();
    idle();
    for (int i = 0; i < 4; i++) begin
      #3; no_stale_check(); #(-0);
      cycle();
    end

    // 17 load-use stalls saturate the narrow counter
    for (int i = 0; i < 17; i++) begin
      idle(); r_emr = 1; r_rd = 5'd7; r_rs1 = 5'd7; r_u1 = 1;
      cycle();
      idle(); cycle();
    end
    chk("stall_cnt_w4_sat", 32'(if4.stall_cnt), 32'hF);
    chk("stall_cnt_w16_17", 32'(if16.stall_cnt), 32'd17);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
